// File: rtl/int_to_fp.sv
// int_to_fp: pipelined two's-complement integer to IEEE-754 converter.
//
// Three stages:
//   S1 - select source lane(s), take sign and absolute value
//   S2 - leading-zero count, normalize magnitude so its MSB sits at bit 31
//   S3 - round, adjust exponent, pack and register the result
// Latency is 3 edges from the accept edge. A single advance signal moves
// every stage together, so backpressure from result_rdy stalls the whole
// pipe without losing or duplicating requests.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   inst_vld   request valid
//   inst_rdy   request can be accepted this cycle
//   src_prec   0 = INT16 source, 1 = INT32 source
//   dst_prec   0 = FP16 result,  1 = FP32 result
//   src_pos    INT16 source half (0 = [15:0], 1 = [31:16]) when src_prec=0
//   dst_pos    FP16 result half  (0 = [15:0], 1 = [31:16]) when dst_prec=0
//   in_reg     integer operand(s)
//   out_reg    IEEE-754 result
//   result_vld out_reg holds a valid result
//   result_rdy downstream takes out_reg this cycle
//
// INT16->FP16 is always the dual-lane subword mode: both halves of in_reg
// are converted independently and src_pos/dst_pos are ignored.
//
// Configuration macro INT2FP_RNE_EN:
//   defined   - round-to-nearest-even, FP16 overflow gives +/-inf
//   undefined - truncate toward zero, FP16 overflow saturates to +/-65504

module int_to_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_vld,
  output logic        inst_rdy,
  input  logic        src_prec,
  input  logic        dst_prec,
  input  logic        src_pos,
  input  logic        dst_pos,
  input  logic [31:0] in_reg,
  output logic [31:0] out_reg,
  output logic        result_vld,
  input  logic        result_rdy
);

  // Count of leading zeros; an all-zero input returns 0 and is flagged
  // separately as a zero operand.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  // exp is the unbiased exponent (MSB position of the magnitude). A round
  // increment that carries out of the mantissa bumps the exponent and
  // leaves an all-zero mantissa, which is the correct next power of two.
  function automatic logic [31:0] pack_fp32(input logic        sign,
                                            input logic [4:0]  exp,
                                            input logic [22:0] mant,
                                            input logic        inc);
    logic [23:0] m;
    logic [7:0]  e;
    m = {1'b0, mant} + {23'd0, inc};
    e = {3'd0, exp} + 8'd127 + {7'd0, m[23]};
    return {sign, e, m[22:0]};
  endfunction

  function automatic logic [15:0] pack_fp16(input logic       sign,
                                            input logic [4:0] exp,
                                            input logic [9:0] mant,
                                            input logic       inc);
    logic [10:0] m;
    logic [5:0]  e;
    m = {1'b0, mant} + {10'd0, inc};
    e = {1'b0, exp} + {5'd0, m[10]};
    if (e > 6'd15) begin
`ifdef INT2FP_RNE_EN
      return {sign, 5'h1F, 10'h000};
`else
      return {sign, 5'h1E, 10'h3FF};
`endif
    end
    return {sign, e[4:0] + 5'd15, m[9:0]};
  endfunction

  logic advance;

  // S1 registers: lane 0 carries INT32 or the selected/low INT16,
  // lane 1 carries the high INT16 in subword mode.
  logic        s1_vld_q,   s1_vld_d;
  logic        s1_sub_q,   s1_sub_d;
  logic        s1_dprec_q, s1_dprec_d;
  logic        s1_dpos_q,  s1_dpos_d;
  logic        s1_sign0_q, s1_sign0_d;
  logic [31:0] s1_mag0_q,  s1_mag0_d;
  logic        s1_sign1_q, s1_sign1_d;
  logic [31:0] s1_mag1_q,  s1_mag1_d;

  // S2 registers
  logic        s2_vld_q,   s2_vld_d;
  logic        s2_sub_q,   s2_sub_d;
  logic        s2_dprec_q, s2_dprec_d;
  logic        s2_dpos_q,  s2_dpos_d;
  logic        s2_sign0_q, s2_sign0_d;
  logic        s2_zero0_q, s2_zero0_d;
  logic [4:0]  s2_exp0_q,  s2_exp0_d;
  logic [31:0] s2_norm0_q, s2_norm0_d;
  logic        s2_sign1_q, s2_sign1_d;
  logic        s2_zero1_q, s2_zero1_d;
  logic [4:0]  s2_exp1_q,  s2_exp1_d;
  logic [31:0] s2_norm1_q, s2_norm1_d;

  // S3 / output registers
  logic        result_vld_q, result_vld_d;
  logic [31:0] out_reg_q,    out_reg_d;

  // Combinational helpers
  logic        sub_mode;
  logic [31:0] lane0_val;
  logic [31:0] lane1_val;
  logic [4:0]  lz0;
  logic [4:0]  lz1;
  logic        inc32_0;
  logic        inc16_0;
  logic        inc16_1;
  logic [15:0] fp16_lo;
  logic [15:0] fp16_hi;
  logic [31:0] fp32_res;
  logic [31:0] packed_res;
  logic        unused_norm_bits;

  assign advance    = !result_vld_q || result_rdy;
  assign inst_rdy   = advance;
  assign out_reg    = out_reg_q;
  assign result_vld = result_vld_q;

  assign sub_mode  = !src_prec && !dst_prec;
  assign lane0_val = src_prec                ? in_reg :
                     (!sub_mode && src_pos)  ? {{16{in_reg[31]}}, in_reg[31:16]} :
                                               {{16{in_reg[15]}}, in_reg[15:0]};
  assign lane1_val = {{16{in_reg[31]}}, in_reg[31:16]};

  // S1: sign and magnitude. Negating the most-negative value wraps to the
  // same bit pattern, which read as unsigned is exactly 2^31 (or 2^15
  // after sign extension), so no special case is needed.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_sub_d   = s1_sub_q;
    s1_dprec_d = s1_dprec_q;
    s1_dpos_d  = s1_dpos_q;
    s1_sign0_d = s1_sign0_q;
    s1_mag0_d  = s1_mag0_q;
    s1_sign1_d = s1_sign1_q;
    s1_mag1_d  = s1_mag1_q;
    if (advance) begin
      s1_vld_d = inst_vld;
      if (inst_vld) begin
        s1_sub_d   = sub_mode;
        s1_dprec_d = dst_prec;
        s1_dpos_d  = dst_pos;
        s1_sign0_d = lane0_val[31];
        s1_mag0_d  = lane0_val[31] ? (32'd0 - lane0_val) : lane0_val;
        s1_sign1_d = lane1_val[31];
        s1_mag1_d  = lane1_val[31] ? (32'd0 - lane1_val) : lane1_val;
      end
    end
  end

  assign lz0 = lzc32(s1_mag0_q);
  assign lz1 = lzc32(s1_mag1_q);

  // S2: normalize so the hidden bit lands at bit 31.
  always_comb begin
    s2_vld_d   = s2_vld_q;
    s2_sub_d   = s2_sub_q;
    s2_dprec_d = s2_dprec_q;
    s2_dpos_d  = s2_dpos_q;
    s2_sign0_d = s2_sign0_q;
    s2_zero0_d = s2_zero0_q;
    s2_exp0_d  = s2_exp0_q;
    s2_norm0_d = s2_norm0_q;
    s2_sign1_d = s2_sign1_q;
    s2_zero1_d = s2_zero1_q;
    s2_exp1_d  = s2_exp1_q;
    s2_norm1_d = s2_norm1_q;
    if (advance) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_sub_d   = s1_sub_q;
        s2_dprec_d = s1_dprec_q;
        s2_dpos_d  = s1_dpos_q;
        s2_sign0_d = s1_sign0_q;
        s2_zero0_d = (s1_mag0_q == 32'd0);
        s2_exp0_d  = 5'd31 - lz0;
        s2_norm0_d = s1_mag0_q << lz0;
        s2_sign1_d = s1_sign1_q;
        s2_zero1_d = (s1_mag1_q == 32'd0);
        s2_exp1_d  = 5'd31 - lz1;
        s2_norm1_d = s1_mag1_q << lz1;
      end
    end
  end

  // Round increment: guard bit set and either sticky bits or an odd LSB.
`ifdef INT2FP_RNE_EN
  assign inc32_0 = s2_norm0_q[7]  & ((|s2_norm0_q[6:0])  | s2_norm0_q[8]);
  assign inc16_0 = s2_norm0_q[20] & ((|s2_norm0_q[19:0]) | s2_norm0_q[21]);
  assign inc16_1 = s2_norm1_q[20] & ((|s2_norm1_q[19:0]) | s2_norm1_q[21]);
  assign unused_norm_bits = s2_norm0_q[31] ^ s2_norm1_q[31];
`else
  assign inc32_0 = 1'b0;
  assign inc16_0 = 1'b0;
  assign inc16_1 = 1'b0;
  assign unused_norm_bits = ^{s2_norm0_q[31], s2_norm0_q[7:0],
                              s2_norm1_q[31], s2_norm1_q[20:0]};
`endif

  // Zero operands bypass packing so the result is always +0.
  assign fp16_lo  = s2_zero0_q ? 16'h0000 :
                    pack_fp16(s2_sign0_q, s2_exp0_q, s2_norm0_q[30:21], inc16_0);
  assign fp16_hi  = s2_zero1_q ? 16'h0000 :
                    pack_fp16(s2_sign1_q, s2_exp1_q, s2_norm1_q[30:21], inc16_1);
  assign fp32_res = s2_zero0_q ? 32'h0000_0000 :
                    pack_fp32(s2_sign0_q, s2_exp0_q, s2_norm0_q[30:8], inc32_0);

  assign packed_res = s2_sub_q   ? {fp16_hi, fp16_lo} :
                      s2_dprec_q ? fp32_res :
                      s2_dpos_q  ? {fp16_lo, 16'h0000} :
                                   {16'h0000, fp16_lo};

  // S3: out_reg only loads when a valid result moves in, so it keeps its
  // last value through bubbles and stalls.
  always_comb begin
    result_vld_d = result_vld_q;
    out_reg_d    = out_reg_q;
    if (advance) begin
      result_vld_d = s2_vld_q;
      if (s2_vld_q) out_reg_d = packed_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_dprec_q   <= 1'b0;
      s1_dpos_q    <= 1'b0;
      s1_sign0_q   <= 1'b0;
      s1_mag0_q    <= 32'd0;
      s1_sign1_q   <= 1'b0;
      s1_mag1_q    <= 32'd0;
      s2_vld_q     <= 1'b0;
      s2_sub_q     <= 1'b0;
      s2_dprec_q   <= 1'b0;
      s2_dpos_q    <= 1'b0;
      s2_sign0_q   <= 1'b0;
      s2_zero0_q   <= 1'b0;
      s2_exp0_q    <= 5'd0;
      s2_norm0_q   <= 32'd0;
      s2_sign1_q   <= 1'b0;
      s2_zero1_q   <= 1'b0;
      s2_exp1_q    <= 5'd0;
      s2_norm1_q   <= 32'd0;
      result_vld_q <= 1'b0;
      out_reg_q    <= 32'd0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_sub_q     <= s1_sub_d;
      s1_dprec_q   <= s1_dprec_d;
      s1_dpos_q    <= s1_dpos_d;
      s1_sign0_q   <= s1_sign0_d;
      s1_mag0_q    <= s1_mag0_d;
      s1_sign1_q   <= s1_sign1_d;
      s1_mag1_q    <= s1_mag1_d;
      s2_vld_q     <= s2_vld_d;
      s2_sub_q     <= s2_sub_d;
      s2_dprec_q   <= s2_dprec_d;
      s2_dpos_q    <= s2_dpos_d;
      s2_sign0_q   <= s2_sign0_d;
      s2_zero0_q   <= s2_zero0_d;
      s2_exp0_q    <= s2_exp0_d;
      s2_norm0_q   <= s2_norm0_d;
      s2_sign1_q   <= s2_sign1_d;
      s2_zero1_q   <= s2_zero1_d;
      s2_exp1_q    <= s2_exp1_d;
      s2_norm1_q   <= s2_norm1_d;
      result_vld_q <= result_vld_d;
      out_reg_q    <= out_reg_d;
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: self-checking bench for int_to_fp.
// A negedge monitor keeps a queue of expected results, pushed on every
// accept from an arithmetic float-rounding model and popped on every
// output handshake. Directed cases pin latency, corner values, stall
// and mid-flight reset; a randomized phase exercises everything else.

module tb_int_to_fp;

`ifdef INT2FP_RNE_EN
  localparam bit RNE_MODE = 1'b1;
`else
  localparam bit RNE_MODE = 1'b0;
`endif

  localparam logic [31:0] CORNER [12] = '{
    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
    32'h7FFF_FFFF, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_FFF0,
    32'h0000_FFEF, 32'h0001_86A0, 32'hFFFE_7960, 32'h8000_7FFF
  };

  logic        clk;
  logic        rst;
  logic        inst_vld;
  logic        inst_rdy;
  logic        src_prec;
  logic        dst_prec;
  logic        src_pos;
  logic        dst_pos;
  logic [31:0] in_reg;
  logic [31:0] out_reg;
  logic        result_vld;
  logic        result_rdy;

  int          tests_run;
  int          tests_failed;
  int          n_results;
  logic [31:0] sb [$];
  logic        have_hold;
  logic [31:0] hold_val;
  logic        saw_stall;

  int_to_fp dut (
    .clk        (clk),
    .rst        (rst),
    .inst_vld   (inst_vld),
    .inst_rdy   (inst_rdy),
    .src_prec   (src_prec),
    .dst_prec   (dst_prec),
    .src_pos    (src_pos),
    .dst_pos    (dst_pos),
    .in_reg     (in_reg),
    .out_reg    (out_reg),
    .result_vld (result_vld),
    .result_rdy (result_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer to binary float with man_bits fraction bits and exp_bits
  // exponent bits, done with plain integer arithmetic.
  function automatic logic [31:0] ref_float(input longint v, input int man_bits,
                                            input int exp_bits);
    longint mag, q, r, half, field;
    int     e, sh, bias;
    logic   sgn, round_up;
    if (v == 0) return 32'd0;
    sgn = (v < 0);
    mag = sgn ? -v : v;
    e = 0;
    while ((longint'(1) << (e + 1)) <= mag) e++;
    if (e > man_bits) begin
      sh = e - man_bits;
      q = mag >> sh;
      r = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      round_up = RNE_MODE && ((r > half) || (r == half && q[0]));
      if (round_up) q++;
    end else begin
      q = mag << (man_bits - e);
    end
    if (q == (longint'(1) << (man_bits + 1))) begin
      q = q >> 1;
      e++;
    end
    bias = (1 << (exp_bits - 1)) - 1;
    if (e > bias) begin
      if (RNE_MODE) field = longint'((1 << exp_bits) - 1) << man_bits;
      else field = (longint'(2 * bias) << man_bits) | ((longint'(1) << man_bits) - 1);
    end else begin
      field = (longint'(e + bias) << man_bits) | (q - (longint'(1) << man_bits));
    end
    if (sgn) field = field | (longint'(1) << (man_bits + exp_bits));
    return field[31:0];
  endfunction

  function automatic longint s16(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic [31:0] expect_out(input logic [31:0] x, input logic sp,
                                             input logic dp, input logic spos,
                                             input logic dpos);
    longint      v;
    logic [31:0] h;
    logic [31:0] l;
    if (!sp && !dp) begin
      h = ref_float(s16(x[31:16]), 10, 5);
      l = ref_float(s16(x[15:0]), 10, 5);
      return {h[15:0], l[15:0]};
    end
    if (sp) v = longint'($signed(x));
    else if (spos) v = s16(x[31:16]);
    else v = s16(x[15:0]);
    if (dp) return ref_float(v, 23, 8);
    h = ref_float(v, 10, 5);
    return dpos ? {h[15:0], 16'h0000} : {16'h0000, h[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_val);
    tests_run++;
    if (obs !== exp_val) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, obs, exp_val);
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      have_hold = 1'b0;
    end else begin
      checkOutput("rdy_rule", 32'(inst_rdy), 32'(!result_vld || result_rdy));
      if (have_hold) checkOutput("stall_hold", out_reg, hold_val);
      if (result_vld && result_rdy) begin
        n_results++;
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) checkOutput("result", out_reg, sb.pop_front());
      end
      have_hold = result_vld && !result_rdy;
      hold_val  = out_reg;
      if (inst_vld && inst_rdy)
        sb.push_back(expect_out(in_reg, src_prec, dst_prec, src_pos, dst_pos));
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [31:0] val, input logic sp, input logic dp,
                               input logic spos, input logic dpos);
    int waited;
    waited   = 0;
    in_reg   = val;
    src_prec = sp;
    dst_prec = dp;
    src_pos  = spos;
    dst_pos  = dpos;
    inst_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (inst_rdy || waited > 50) break;
      waited++;
    end
    checkOutput("accept_wait", 32'(inst_rdy), 32'd1);
    @(posedge clk);
    #1 inst_vld = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    result_rdy = 1'b1;
    while ((sb.size() != 0 || result_vld) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  // Single request on an idle pipe: checks exact 3-edge latency and value.
  task automatic runDirected(input string tag, input logic [31:0] val, input logic sp,
                             input logic dp, input logic spos, input logic dpos,
                             input logic [31:0] exp_val);
    waitIdle();
    @(posedge clk);
    #1;
    in_reg   = val;
    src_prec = sp;
    dst_prec = dp;
    src_pos  = spos;
    dst_pos  = dpos;
    inst_vld = 1'b1;
    checkOutput({tag, "_rdy"}, 32'(inst_rdy), 32'd1);
    @(posedge clk);
    #1 inst_vld = 1'b0;
    @(posedge clk);
    #1 checkOutput({tag, "_early"}, 32'(result_vld), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_vld"}, 32'(result_vld), 32'd1);
    checkOutput(tag, out_reg, exp_val);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sh;
    logic [31:0] val;
    tests_run    = 0;
    tests_failed = 0;
    n_results    = 0;
    have_hold    = 1'b0;
    saw_stall    = 1'b0;
    rst          = 1'b1;
    inst_vld     = 1'b0;
    result_rdy   = 1'b1;
    src_prec     = 1'b0;
    dst_prec     = 1'b0;
    src_pos      = 1'b0;
    dst_pos      = 1'b0;
    in_reg       = 32'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_vld", 32'(result_vld), 32'd0);
    checkOutput("reset_out", out_reg, 32'd0);
    checkOutput("reset_rdy", 32'(inst_rdy), 32'd1);

    runDirected("i32_one",    32'h0000_0001, 1, 1, 0, 0, 32'h3F80_0000);
    runDirected("i32_minneg", 32'h8000_0000, 1, 1, 0, 0, 32'hCF00_0000);
    runDirected("i32_max",    32'h7FFF_FFFF, 1, 1, 0, 0,
                RNE_MODE ? 32'h4F00_0000 : 32'h4EFF_FFFF);
    runDirected("i32_zero",   32'h0000_0000, 1, 1, 0, 0, 32'h0000_0000);
    runDirected("sub_pm1",    32'hFFFF_0001, 0, 0, 1, 1, 32'hBC00_3C00);
    runDirected("sub_max",    32'h7FFF_0000, 0, 0, 0, 0,
                RNE_MODE ? 32'h7800_0000 : 32'h77FF_0000);
    runDirected("sub_minneg", 32'h8000_8000, 0, 0, 0, 0, 32'hF800_F800);
    runDirected("i16_hi_f32", 32'h8000_1234, 0, 1, 1, 0, 32'hC700_0000);
    runDirected("f16_ovf",    32'h0001_86A0, 1, 0, 0, 0,
                RNE_MODE ? 32'h0000_7C00 : 32'h0000_7BFF);
    runDirected("f16_neg_ovf", 32'hFFFE_7960, 1, 0, 0, 0,
                RNE_MODE ? 32'h0000_FC00 : 32'h0000_FBFF);
    runDirected("f16_65520",  32'h0000_FFF0, 1, 0, 0, 0,
                RNE_MODE ? 32'h0000_7C00 : 32'h0000_7BFF);
    runDirected("f16_65519",  32'h0000_FFEF, 1, 0, 0, 0, 32'h0000_7BFF);
    runDirected("f16_hipos",  32'h0000_0003, 1, 0, 0, 1, 32'h4200_0000);

    // Backpressure: 5 back-to-back requests against a stalled output.
    waitIdle();
    sh = n_results;
    @(posedge clk);
    #1 result_rdy = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++)
          applyStimulus($urandom, 1'b1, 1'(k % 2), 1'b0, 1'(k / 2 % 2));
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (!inst_rdy) saw_stall = 1'b1;
        end
        @(posedge clk);
        #1 result_rdy = 1'b1;
      end
    join
    checkOutput("stall_rdy_drop", 32'(saw_stall), 32'd1);
    waitIdle();
    checkOutput("stall_count", 32'(n_results - sh), 32'd5);

    // Reset with two requests in flight.
    waitIdle();
    @(posedge clk);
    #1;
    src_prec = 1'b1;
    dst_prec = 1'b1;
    in_reg   = 32'h0000_0005;
    inst_vld = 1'b1;
    @(posedge clk);
    #1 in_reg = 32'h0000_0006;
    @(posedge clk);
    #1;
    inst_vld = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_rdy", 32'(inst_rdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_vld", 32'(result_vld), 32'd0);
      checkOutput("rst_out", out_reg, 32'd0);
      @(posedge clk);
      #1;
    end
    runDirected("rst_next", 32'h0000_0001, 1, 1, 0, 0, 32'h3F80_0000);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      inst_vld   = ($urandom_range(0, 3) != 0);
      result_rdy = ($urandom_range(0, 9) < 7);
      src_prec   = 1'($urandom_range(0, 1));
      dst_prec   = 1'($urandom_range(0, 1));
      src_pos    = 1'($urandom_range(0, 1));
      dst_pos    = 1'($urandom_range(0, 1));
      sh         = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       val = $urandom;
        1:       val = 32'($urandom) >> sh;
        2:       val = 32'd0 - (32'($urandom) >> sh);
        default: val = CORNER[$urandom_range(0, 11)];
      endcase
      in_reg = val;
    end
    @(posedge clk);
    #1 inst_vld = 1'b0;
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
